// File: rtl/data_memory_be_pkg.sv
// Shared RV32I load/store definitions and the decode helpers used by the data memory.
package data_memory_be_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned LANES   = 4;

    typedef enum logic [1:0] {
        SZ_B   = 2'd0,
        SZ_H   = 2'd1,
        SZ_W   = 2'd2,
        SZ_BAD = 2'd3
    } lsu_size_t;

    // Access size implied by funct3; unsigned variants share the signed size.
    function automatic lsu_size_t f3_size(input logic [2:0] f3);
        lsu_size_t sz;
        case (f3)
            F3_B, F3_BU: sz = SZ_B;
            F3_H, F3_HU: sz = SZ_H;
            F3_W:        sz = SZ_W;
            default:     sz = SZ_BAD;
        endcase
        return sz;
    endfunction

    // Byte lanes touched by an access of the given size at the given lane offset.
    function automatic logic [3:0] lane_mask(input lsu_size_t sz, input logic [1:0] lo);
        logic [3:0] m;
        case (sz)
            SZ_B:    m = 4'b0001 << lo;
            SZ_H:    m = 4'b0011 << lo;
            SZ_W:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Store data copied into every lane so the mask alone picks the destination.
    function automatic logic [31:0] replicate(input lsu_size_t sz, input logic [31:0] wd);
        logic [31:0] r;
        case (sz)
            SZ_B:    r = {4{wd[7:0]}};
            SZ_H:    r = {2{wd[15:0]}};
            default: r = wd;
        endcase
        return r;
    endfunction

    // Natural alignment check for halfword and word accesses.
    function automatic logic misaligned(input lsu_size_t sz, input logic [1:0] lo);
        logic m;
        case (sz)
            SZ_H:    m = lo[0];
            SZ_W:    m = |lo;
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/data_memory_be_load_align.sv
// Load data alignment: picks the addressed byte/half from a word and sign or zero extends it.
module data_memory_be_load_align
    import data_memory_be_pkg::*;
(
    input  logic [31:0] rdata_word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection followed by extension according to funct3.
    always_comb begin
        rdata    = 32'h0;
        byte_sel = 8'h0;
        half_sel = addr_lo[1] ? rdata_word[31:16] : rdata_word[15:0];
        case (addr_lo)
            2'd0:    byte_sel = rdata_word[7:0];
            2'd1:    byte_sel = rdata_word[15:8];
            2'd2:    byte_sel = rdata_word[23:16];
            default: byte_sel = rdata_word[31:24];
        endcase
        case (funct3)
            F3_B:    rdata = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   rdata = {24'h0, byte_sel};
            F3_H:    rdata = {{16{half_sel[15]}}, half_sel};
            F3_HU:   rdata = {16'h0, half_sel};
            F3_W:    rdata = rdata_word;
            default: rdata = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_memory_be.sv
// Byte-addressable RV32I data memory with byte-enable stores, extended loads,
// error reporting and a single-entry response register with backpressure.
module data_memory_be
    import data_memory_be_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IDX_W = ADDR_WIDTH - 2;
    localparam int unsigned DEPTH = 2 ** IDX_W;

    lsu_size_t         req_size;
    logic              req_err;
    logic              accept;
    logic              load_ok;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        wr_be;
    logic [31:0]       wr_data;
    logic [31:0]       rd_bytes;
    logic [31:0]       align_rdata;

    logic              rsp_valid_d, rsp_valid_q;
    logic              rsp_err_d,   rsp_err_q;
    logic              load_en_d,   load_en_q;
    logic [31:0]       rd_word_d,   rd_word_q;
    logic [1:0]        addr_lo_d,   addr_lo_q;
    logic [2:0]        funct3_d,    funct3_q;

    // A new request can enter whenever the response slot is empty or being drained.
    assign req_ready = !rsp_valid_q || rsp_ready;
    assign accept    = req_valid && req_ready;
    assign idx       = req_addr[ADDR_WIDTH-1:2];

    // Request decode: size, error conditions and store lane enables.
    always_comb begin
        req_size = f3_size(req_funct3);
        req_err  = (req_size == SZ_BAD)
                 || misaligned(req_size, req_addr[1:0])
                 || (|req_addr[31:ADDR_WIDTH])
                 || (req_we && req_funct3[2]);
        load_ok  = accept && !req_we && !req_err;
        wr_data  = replicate(req_size, req_wdata);
        wr_be    = 4'b0000;
        if (accept && req_we && !req_err && !rst) begin
            wr_be = lane_mask(req_size, req_addr[1:0]);
        end
    end

    for (genvar b = 0; b < LANES; b++) begin : g_bank
        logic [7:0] mem [DEPTH];

        // One byte-wide bank per lane, written only when its lane is enabled.
        always_ff @(posedge clk) begin
            if (wr_be[b]) begin
                mem[idx] <= wr_data[8*b +: 8];
            end
        end

        assign rd_bytes[8*b +: 8] = mem[idx];
    end

    // Response register next-state: load on accept, drain on handshake, otherwise hold.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        load_en_d   = load_en_q;
        rd_word_d   = rd_word_q;
        addr_lo_d   = addr_lo_q;
        funct3_d    = funct3_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = req_err;
            load_en_d   = load_ok;
            rd_word_d   = load_ok ? rd_bytes : 32'h0;
            addr_lo_d   = req_addr[1:0];
            funct3_d    = req_funct3;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Response register state; reset discards any pending response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            load_en_q   <= 1'b0;
            rd_word_q   <= 32'h0;
            addr_lo_q   <= 2'd0;
            funct3_q    <= 3'd0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            load_en_q   <= load_en_d;
            rd_word_q   <= rd_word_d;
            addr_lo_q   <= addr_lo_d;
            funct3_q    <= funct3_d;
        end
    end

    data_memory_be_load_align u_load_align (
        .rdata_word (rd_word_q),
        .addr_lo    (addr_lo_q),
        .funct3     (funct3_q),
        .rdata      (align_rdata)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = load_en_q ? align_rdata : 32'h0;

endmodule

// File: tb/tb_data_memory_be.sv
// Scoreboard bench for data_memory_be: the driver queues expected responses,
// a negedge monitor checks each response on its handshake and its latency.
module tb_data_memory_be;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   cyc;
    int   checks;
    int   errors;
    int   last_acc;
    int   rel_cyc;
    bit   fresh;

    data_memory_be dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Present one request, queue its expected response, wait (bounded) for acceptance.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
        bit got;
        bit rdy;
        exp_t e;
        e.err   = exp_err;
        e.rdata = exp_rd;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        exp_q.push_back(e);
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            rdy = req_ready;
            @(posedge clk);
            #1;
            if (rdy) got = 1'b1;
        end
        if (got) begin
            acc_q.push_back(cyc);
            last_acc = cyc;
        end else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: addr 0x%08h not accepted within 50 cycles", addr);
            void'(exp_q.pop_back());
        end
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: latency of each new response, and contents on every handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_valid && fresh) begin
                if (acc_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: response with no accepted request at cycle %0d", cyc);
                end else begin
                    chk("latency", 32'(cyc), 32'(acc_q.pop_front()));
                end
                fresh = 1'b0;
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_handshake: rdata 0x%08h err %0b", rsp_rdata, rsp_err);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
                end
                fresh = 1'b1;
            end
        end
    end

    initial begin
        cyc        = 0;
        checks     = 0;
        errors     = 0;
        last_acc   = 0;
        rel_cyc    = 0;
        fresh      = 1'b1;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        rsp_ready  = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        chk("reset_rsp_err", {31'h0, rsp_err}, 32'h0);
        chk("reset_req_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1;

        // Word store and load
        do_req(1'b1, 3'b010, 32'h10, 32'h12345678, 32'h0, 1'b0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'h12345678, 1'b0);

        // Byte store into lane 1, signed/unsigned byte loads, merged word
        do_req(1'b1, 3'b000, 32'h11, 32'h000000AB, 32'h0, 1'b0);
        do_req(1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFAB, 1'b0);
        do_req(1'b0, 3'b100, 32'h11, 32'h0, 32'h000000AB, 1'b0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'h1234AB78, 1'b0);

        // Upper half store, half loads, misaligned and illegal-funct3 errors
        do_req(1'b1, 3'b001, 32'h12, 32'h00008001, 32'h0, 1'b0);
        do_req(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF8001, 1'b0);
        do_req(1'b0, 3'b101, 32'h12, 32'h0, 32'h00008001, 1'b0);
        do_req(1'b0, 3'b001, 32'h13, 32'h0, 32'h0, 1'b1);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'h8001AB78, 1'b0);
        do_req(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0);
        do_req(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
        do_req(1'b1, 3'b100, 32'h10, 32'h000000FF, 32'h0, 1'b1);
        do_req(1'b1, 3'b001, 32'h11, 32'h0000FFFF, 32'h0, 1'b1);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'h8001AB78, 1'b0);

        // Out-of-range accesses never write (index aliases to word 0)
        do_req(1'b1, 3'b010, 32'h0, 32'h00000000, 32'h0, 1'b0);
        do_req(1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b1);
        do_req(1'b1, 3'b010, 32'h400, 32'hCAFEF00D, 32'h0, 1'b1);
        do_req(1'b1, 3'b010, 32'h402, 32'hCAFEF00D, 32'h0, 1'b1);
        do_req(1'b0, 3'b010, 32'h0, 32'h0, 32'h0, 1'b0);
        idle(1);

        // Backpressure: response held for 3 sampled cycles, next request waits
        rsp_ready = 1'b0;
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'h8001AB78, 1'b0);
        fork
            do_req(1'b0, 3'b100, 32'h10, 32'h0, 32'h00000078, 1'b0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_req_ready", {31'h0, req_ready}, 32'h0);
                    chk("stall_rsp_valid", {31'h0, rsp_valid}, 32'h1);
                    chk("stall_rsp_rdata", rsp_rdata, 32'h8001AB78);
                end
                @(posedge clk);
                #1;
                rsp_ready = 1'b1;
                rel_cyc = cyc;
            end
        join
        chk("release_accept_edge", 32'(last_acc), 32'(rel_cyc + 1));
        idle(2);

        // Reset with a held response and a blocked store pending
        rsp_ready = 1'b0;
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'h8001AB78, 1'b0);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h10;
        req_wdata  = 32'hDEADBEEF;
        @(negedge clk);
        chk("pre_rst_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        chk("pre_rst_req_ready", {31'h0, req_ready}, 32'h0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst_async_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_async_rsp_rdata", rsp_rdata, 32'h0);
        exp_q.delete();
        acc_q.delete();
        fresh = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'h8001AB78, 1'b0);
        idle(1);

        for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge clk);
        chk("drain_expected", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
